// File: rtl/kb_pkg.sv
// kb_pkg: shared constants for the keyboard line-assembly path.
//   KEY_*     : scan codes with special meaning, also used by the keyboard front end.
//   ST_*      : state encoding for the kb_line_buf sequencer.
package kb_pkg;

    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_CAPS  = 8'h58;

    localparam logic [1:0] ST_POP    = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/kb_code2ascii.sv
// kb_code2ascii: combinational scan-code to ASCII translation.
//   code      in  8  scan code
//   caps      in  1  caps-lock state (affects letters only)
//   ascii     out 8  translated character (0x00 when not printable)
//   printable out 1  code maps to a character that goes into the line
module kb_code2ascii (
    input  logic [7:0] code,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       printable
);

    logic [7:0] lower;
    logic       is_letter;

    always_comb begin
        lower     = 8'h00;
        is_letter = 1'b1;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            default: is_letter = 1'b0;
        endcase
    end

    always_comb begin
        ascii     = 8'h00;
        printable = 1'b1;
        if (is_letter) begin
            // Upper case sits exactly 0x20 below lower case.
            ascii = caps ? (lower - 8'h20) : lower;
        end else begin
            case (code)
                8'h45: ascii = 8'h30;
                8'h16: ascii = 8'h31;
                8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;
                8'h25: ascii = 8'h34;
                8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;
                8'h3D: ascii = 8'h37;
                8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = 8'h20;
                default: printable = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/kb_line_buf.sv
// kb_line_buf: pops scan codes from the keyboard FIFO, builds a text line
// with backspace / caps-lock handling and hands it over on Enter.
//   clk, reset    : system clock, synchronous active-high reset
//   kb_buf_empty  : keyboard FIFO empty flag
//   key_code      : keyboard FIFO head (show-ahead)
//   rd_key_code   : one-cycle pop strobe to the keyboard FIFO
//   line_ready    : committed line held, waiting for line_ack
//   line_len      : characters currently in the line, 0..DEPTH
//   rd_addr/rd_data : random-access readout, one-cycle latency
//   line_ack      : consumer releases the committed line
//   caps          : caps-lock state
//   overflow      : sticky, a printable key was dropped on a full line
module kb_line_buf
    import kb_pkg::*;
#(
    parameter int LINE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              kb_buf_empty,
    input  logic [7:0]        key_code,
    output logic              rd_key_code,
    output logic              line_ready,
    output logic [LINE_W:0]   line_len,
    input  logic [LINE_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              line_ack,
    output logic              caps,
    output logic              overflow
);

    localparam int DEPTH = 2**LINE_W;
    localparam logic [LINE_W:0] FULL_LEN = (LINE_W+1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [LINE_W:0]   line_len_q, line_len_d;
    logic              caps_q, caps_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic [7:0]        line_mem [DEPTH];
    logic              wr_en;
    logic [7:0]        ascii;
    logic              printable;

    kb_code2ascii u_code2ascii (
        .code      (code_q),
        .caps      (caps_q),
        .ascii     (ascii),
        .printable (printable)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        line_len_d = line_len_q;
        caps_d     = caps_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            ST_POP: begin
                if (!kb_buf_empty) begin
                    code_d  = key_code;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_POP;
                if (code_q == KEY_BKSP) begin
                    if (line_len_q != '0) line_len_d = line_len_q - 1'b1;
                end else if (code_q == KEY_ENTER) begin
                    state_d = ST_COMMIT;
                end else if (code_q == KEY_CAPS) begin
                    caps_d = ~caps_q;
                end else if (printable) begin
                    if (line_len_q < FULL_LEN) begin
                        wr_en      = 1'b1;
                        line_len_d = line_len_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                if (line_ack) begin
                    line_len_d = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_POP;
                end
            end
            default: state_d = ST_POP;
        endcase
    end

    // Read-before-write: a same-cycle write to rd_addr is seen one cycle later.
    always_comb rd_data_d = line_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_POP;
            code_q     <= 8'h00;
            line_len_q <= '0;
            caps_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            line_len_q <= line_len_d;
            caps_q     <= caps_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) line_mem[line_len_q[LINE_W-1:0]] <= ascii;
    end

    // Pop is suppressed while reset is held so the FIFO never loses a code
    // that this block is about to abandon.
    assign rd_key_code = (state_q == ST_POP) && !kb_buf_empty && !reset;
    assign line_ready  = (state_q == ST_COMMIT);
    assign line_len    = line_len_q;
    assign rd_data     = rd_data_q;
    assign caps        = caps_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/kb_line_buf.md
# kb_line_buf

Line-assembly stage downstream of the PS/2 keyboard scan-code front end. Pops released-key scan codes from the keyboard FIFO and translates printable keys to ASCII. Builds a line in an internal buffer with backspace and caps-lock handling. On Enter it presents the completed line to a consumer through a random-access read port and an ack handshake.

## Interface
Parameters:
- `LINE_W`, 4: log2 of line buffer depth; `DEPTH = 2**LINE_W` characters.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `kb_buf_empty`  in  1  keyboard FIFO empty flag.
- `key_code`  in  8  keyboard FIFO head. Show-ahead: valid whenever `kb_buf_empty`=0.
- `rd_key_code`  out  1  one-cycle pop strobe to the keyboard FIFO.
- `line_ready`  out  1  a committed line is held and readable.
- `line_len`  out  LINE_W+1  number of characters in the buffer, 0..DEPTH.
- `rd_addr`  in  LINE_W  character index for readout.
- `rd_data`  out  8  ASCII at `rd_addr`, registered.
- `line_ack`  in  1  consumer done with the line; qualified only while `line_ready`=1.
- `caps`  out  1  current caps-lock state.
- `overflow`  out  1  sticky: a printable key was dropped because the buffer was full.

## Operation
- FSM with states POP, DECODE, COMMIT. Reset state is POP.
- **POP:**
  - If `kb_buf_empty`=0, assert `rd_key_code` for exactly one cycle, latch `key_code` into `code_reg`, and go to DECODE.
  - Otherwise stay in POP with `rd_key_code`=0.
- **DECODE** (one cycle, then back to POP unless noted):
  - 0x66 Backspace: if `line_len`>0, decrement. At 0, no effect.
  - 0x5A Enter: go to COMMIT. An empty line (`line_len`=0) is still committed.
  - 0x58 Caps Lock: toggle `caps`.
  - Printable (see mapping):
    - If `line_len`<DEPTH, write the ASCII to `buf[line_len]` and increment.
    - Else drop the character and set `overflow`=1.
  - Any other code: ignored, no state change.
- **COMMIT:**
  - `line_ready`=1. No pops; the upstream FIFO absorbs keystrokes, and its overflow policy is upstream's concern.
  - On `line_ack`=1: clear `line_len` to 0 and `overflow` to 0, then go to POP.
  - Buffer contents are not cleared.
- **Mapping:**
  - Letters: 0x1C a, 0x32 b, 0x21 c, 0x23 d, 0x24 e, 0x2B f, 0x34 g, 0x33 h, 0x43 i, 0x3B j, 0x42 k, 0x4B l, 0x3A m, 0x31 n, 0x44 o, 0x4D p, 0x15 q, 0x2D r, 0x1B s, 0x2C t, 0x3C u, 0x2A v, 0x1D w, 0x22 x, 0x35 y, 0x1A z.
  - Letters are lowercase (0x61-0x7A) when `caps`=0 and uppercase (0x41-0x5A) when `caps`=1.
  - Digits: 0x45 '0', 0x16 '1', 0x1E '2', 0x26 '3', 0x25 '4', 0x2E '5', 0x36 '6', 0x3D '7', 0x3E '8', 0x46 '9'.
  - 0x29 is space (0x20).
  - Digits and space are unaffected by `caps`.
- `rd_data` is always readable, including outside COMMIT. It returns stale contents at indices ≥ `line_len`.

## Timing
- **Reset values:** `rd_key_code`=0, `line_ready`=0, `line_len`=0, `rd_data`=0x00, `caps`=0, `overflow`=0. The state machine resets to POP. Buffer RAM is not reset.
- Reset asserted in any state returns to POP on the next edge, abandoning any latched code or line.
- **Throughput:** at most one pop every 2 cycles (POP→DECODE→POP).
- **Line length:** a printable key popped at edge N is reflected in `line_len` after edge N+2.
- **Line commit:**
  - Enter popped at edge N gives `line_ready`=1 after edge N+2.
  - `line_ack` sampled high at edge M gives `line_ready`=0 and `line_len`=0 after M. The earliest next pop is asserted in the cycle after M.
- **Readout:** `rd_data` reflects `rd_addr` sampled at the previous edge (1-cycle latency).
- If a buffer write in DECODE targets the address being read in the same cycle, `rd_data` returns the old contents.
- `line_ack` outside COMMIT is ignored.

## Structure
- Package `kb_pkg` holds these constants:
  - `KEY_BKSP`=8'h66, `KEY_ENTER`=8'h5A, `KEY_CAPS`=8'h58, shared with the keyboard front end.
  - The state encoding for POP, DECODE and COMMIT.
- Sub-module `kb_code2ascii`: purely combinational.
  - Inputs: `code` [7:0] and `caps`.
  - Outputs: `ascii` [7:0] and `printable`.
- Line buffer is a DEPTH×8 register array with a synchronous read port, inferable as distributed RAM.

## Test plan
- Reset, then idle with `kb_buf_empty`=1 → all outputs at reset values and `rd_key_code` never asserted.
- FIFO supplies 0x1C, 0x16, 0x5A → `line_ready`=1 and `line_len`=2. `rd_addr`=0 gives `rd_data`=0x61 next cycle; `rd_addr`=1 gives 0x31. `line_ack` then gives `line_len`=0.
- Supply 0x58, 0x1C, 0x58, 0x1C, 0x5A → `caps` toggles 1 then 0, and the buffer holds 0x41, 0x61.
- Supply 0x66 with an empty line, then 0x2D, 0x66, 0x5A → `line_len` stays at 0, rises to 1, returns to 0, and an empty line commits.
- Supply 17 × 0x1C with `LINE_W`=4, then 0x5A → `line_len`=16, `overflow`=1 until `line_ack`, and all 16 entries are 0x61.
- Keep `kb_buf_empty`=0 while `line_ready`=1 → `rd_key_code` stays 0 until the ack. Assert `reset` mid-COMMIT → the next cycle shows reset values.
